// File: rtl/muldiv_pkg.sv
// Shared types and op-class masks for the iterative multiply/divide unit.
// Op-class masks are indexed by muldiv_op_t value (bit n describes op n).
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_MADD  = 3'd2,
      OP_MADDU = 3'd3,
      OP_MSUB  = 3'd4,
      OP_MSUBU = 3'd5,
      OP_DIV   = 3'd6,
      OP_DIVU  = 3'd7
   } muldiv_op_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } muldiv_state_t;

   localparam logic [7:0] SIGNED_OPS = 8'b0101_0101;
   localparam logic [7:0] ACC_OPS    = 8'b0011_1100;
   localparam logic [7:0] SUB_OPS    = 8'b0011_0000;
   localparam logic [7:0] DIV_OPS    = 8'b1100_0000;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module muldiv_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             dvd_bit_i,
   input  logic [WIDTH-1:0] dsr_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem_i < dsr_i always holds, so the W+1-bit difference sign is exact
   assign shifted = {rem_i, dvd_bit_i};
   assign diff    = shifted - {1'b0, dsr_i};
   assign q_o     = ~diff[WIDTH];
   assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply(-accumulate) and restoring divide unit.
// Define MULDIV_DIV_EN to build the DIV state; otherwise DIV/DIVU finish in 2 cycles with zeros and div0_o.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  muldiv_op_t    op_i,
   input  logic          flush_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   output logic          ready_o,
   output logic          stall_o,
   output logic          done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic          div0_o,
   output muldiv_state_t dbg_state_o
);

   muldiv_state_t    state;
   logic [CNT_W-1:0] cnt;
   muldiv_op_t       op_q;
   logic [WIDTH-1:0] p_hi, p_lo, mcand, acc_hi, acc_lo;
   logic             neg_p, neg_r, spec_q;

   logic             rs_neg, rt_neg;
   logic [WIDTH-1:0] rs_mag, rt_mag;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic [2*WIDTH-1:0] prod, fix_res;

   assign ready_o     = (state == S_IDLE);
   assign stall_o     = (start_i & ready_o) | ((state != S_IDLE) && (state != S_DONE));
   assign dbg_state_o = state;

   assign rs_neg = SIGNED_OPS[op_i] & rs_i[WIDTH-1];
   assign rt_neg = SIGNED_OPS[op_i] & rt_i[WIDTH-1];
   assign rs_mag = rs_neg ? -rs_i : rs_i;
   assign rt_mag = rt_neg ? -rt_i : rt_i;

   // Multiplier sits in p_lo and shifts out LSB-first while the product fills p_hi:p_lo
   assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

   muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (p_hi),
      .dvd_bit_i (p_lo[WIDTH-1]),
      .dsr_i     (mcand),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

`ifndef MULDIV_DIV_EN
   logic unused_div;
   assign unused_div = ^{step_rem, step_q};
`endif

   always_comb begin
      prod    = {p_hi, p_lo};
      if (neg_p) prod = -prod;
      fix_res = prod;
      if (ACC_OPS[op_q])
         fix_res = SUB_OPS[op_q] ? prod - {acc_hi, acc_lo} : prod + {acc_hi, acc_lo};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_q   <= OP_MULT;
         p_hi   <= '0;
         p_lo   <= '0;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
         spec_q <= 1'b0;
         done_o <= 1'b0;
         div0_o <= 1'b0;
         hi_o   <= '0;
         lo_o   <= '0;
      end else begin
         done_o <= 1'b0;
         if (flush_i) begin
            state <= S_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: if (start_i) begin
                  op_q   <= op_i;
                  acc_hi <= hi_i;
                  acc_lo <= lo_i;
                  cnt    <= '0;
                  p_hi   <= '0;
                  p_lo   <= rs_mag;
                  mcand  <= rt_mag;
                  neg_p  <= rs_neg ^ rt_neg;
                  neg_r  <= rs_neg;
                  spec_q <= 1'b0;
                  if (DIV_OPS[op_i]) begin
`ifdef MULDIV_DIV_EN
                     if (rt_i == '0) begin
                        p_hi   <= rs_i;
                        p_lo   <= '1;
                        spec_q <= 1'b1;
                        state  <= S_FIX;
                     end else begin
                        state  <= S_DIV;
                     end
`else
                     p_lo   <= '0;
                     spec_q <= 1'b1;
                     state  <= S_FIX;
`endif
                  end else begin
                     state <= S_MUL;
                  end
               end
               S_MUL: begin
                  p_hi <= mul_sum[WIDTH:1];
                  p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                  cnt  <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH-1)) state <= S_FIX;
               end
`ifdef MULDIV_DIV_EN
               S_DIV: begin
                  p_hi <= step_rem;
                  p_lo <= {p_lo[WIDTH-2:0], step_q};
                  cnt  <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH-1)) state <= S_FIX;
               end
`endif
               S_FIX: begin
                  // spec_q marks results fixed at accept (zero divisor or divider not built)
                  if (spec_q) begin
                     hi_o   <= p_hi;
                     lo_o   <= p_lo;
                     div0_o <= 1'b1;
                  end else if (DIV_OPS[op_q]) begin
                     hi_o   <= neg_r ? -p_hi : p_hi;
                     lo_o   <= neg_p ? -p_lo : p_lo;
                     div0_o <= 1'b0;
                  end else begin
                     hi_o   <= fix_res[2*WIDTH-1:WIDTH];
                     lo_o   <= fix_res[WIDTH-1:0];
                     div0_o <= 1'b0;
                  end
                  done_o <= 1'b1;
                  state  <= S_DONE;
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit (WIDTH=32) against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   muldiv_op_t    op = OP_MULT;
   logic [W-1:0]  rs = '0, rt = '0, hi_in = '0, lo_in = '0;
   logic          ready, stall, done, div0;
   logic [W-1:0]  hi_out, lo_out;
   muldiv_state_t dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // {expected done cycle[96:65], div0[64], hi[63:32], lo[31:0]}
   logic [96:0] exp_q[$];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .op_i        (op),
      .flush_i     (flush),
      .rs_i        (rs),
      .rt_i        (rt),
      .hi_i        (hi_in),
      .lo_i        (lo_in),
      .ready_o     (ready),
      .stall_o     (stall),
      .done_o      (done),
      .hi_o        (hi_out),
      .lo_o        (lo_out),
      .div0_o      (div0),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain 64-bit arithmetic. Returns {div0, hi, lo}.
   function automatic logic [64:0] ref_model(muldiv_op_t o, logic [W-1:0] a, logic [W-1:0] b,
                                             logic [W-1:0] h, logic [W-1:0] l);
      longint sa, sb, q, r;
      logic [63:0] p;
      if (o == OP_MULT || o == OP_MADD || o == OP_MSUB || o == OP_DIV) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      if (o == OP_DIV || o == OP_DIVU) begin
`ifdef MULDIV_DIV_EN
         if (b == '0) return {1'b1, a, {W{1'b1}}};
         q = sa / sb;
         r = sa % sb;
         return {1'b0, r[W-1:0], q[W-1:0]};
`else
         q = 0;
         r = 0;
         return {1'b1, q[W-1:0], r[W-1:0]};
`endif
      end
      p = sa * sb;
      if (o == OP_MADD || o == OP_MADDU) p = p + {h, l};
      if (o == OP_MSUB || o == OP_MSUBU) p = p - {h, l};
      return {1'b0, p};
   endfunction

   function automatic int ref_latency(muldiv_op_t o, logic [W-1:0] b);
      if (o == OP_DIV || o == OP_DIVU) begin
`ifdef MULDIV_DIV_EN
         if (b == '0) return 2;
`else
         return 2;
`endif
      end
      return W + 2;
   endfunction

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return {W{1'b1}};
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return W'($urandom_range(0, 15));
         4:       return {W{1'b1}} - W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   // driver: wait for ready, accept one op; optionally push expectation and poke start while busy
   task automatic issue(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] h, input logic [W-1:0] l, input bit expect_it);
      int t = 0;
      @(negedge clk);
      while (!ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!ready) begin
         check("ready_timeout", 64'(ready), 64'd1);
         return;
      end
      op = o; rs = a; rt = b; hi_in = h; lo_in = l;
      start = 1'b1;
      if (expect_it) exp_q.push_back({32'(cyc + ref_latency(o, b)), ref_model(o, a, b, h, l)});
      @(posedge clk);
      #1 start = 1'b0;
      if (expect_it) begin
         @(negedge clk);
         check("busy_ready", 64'(ready), 64'd0);
         check("busy_stall", 64'(stall), 64'd1);
         op = muldiv_op_t'($urandom_range(0, 7));
         rs = W'($urandom); rt = W'($urandom); hi_in = W'($urandom); lo_in = W'($urandom);
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // flush an op 'at' cycles after its accept cycle, with start_i also high
   task automatic flush_test(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int at);
      issue(o, a, b, '0, '0, 1'b0);
      repeat (at) @(negedge clk);
      flush = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 begin flush = 1'b0; start = 1'b0; end
      @(negedge clk);
      check("flush_ready", 64'(ready), 64'd1);
      check("flush_state", 64'(dbg_state), 64'(S_IDLE));
      repeat (40) @(negedge clk);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [96:0] e;
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("done_cycle", 64'(cyc), 64'(e[96:65]));
            check("hi", 64'(hi_out), 64'(e[63:32]));
            check("lo", 64'(lo_out), 64'(e[31:0]));
            check("div0", 64'(div0), 64'(e[64]));
         end
      end
   end

   initial begin
      muldiv_op_t o;
      #1 rst_n = 1'b0;
      #2;
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_div0", 64'(div0), 64'd0);
      check("rst_hilo", {hi_out, lo_out}, 64'd0);
      check("rst_state", 64'(dbg_state), 64'(S_IDLE));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // directed corner cases
      issue(OP_MULT,  32'hFFFF_FFFE, 32'd3,         '0,   '0,    1'b1);
      issue(OP_MSUBU, 32'd4,         32'd3,         '0,   32'd10, 1'b1);
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         '0,   '0,    1'b1);
      issue(OP_DIVU,  32'h0000_1234, 32'd0,         '0,   '0,    1'b1);
      issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, '0,   '0,    1'b1);
      issue(OP_MADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0,   '0,    1'b1);
      issue(OP_DIVU,  32'hFFFF_FFFF, 32'd7,         '0,   '0,    1'b1);

      // randomized back-to-back traffic
      for (int i = 0; i < 40; i++) begin
         o = muldiv_op_t'($urandom_range(0, 7));
         issue(o, pick_val(), ($urandom_range(0, 7) == 0) ? '0 : pick_val(),
               W'($urandom), W'($urandom), 1'b1);
      end
      drain();

      // flush during MUL, during FIX after multiply, during FIX of a zero-divisor op
      flush_test(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 10);
      flush_test(OP_MULT,  32'hFFFF_FFF0, 32'd5, 33);
      flush_test(OP_DIVU,  32'd55, 32'd0, 1);

      // flush beats start while idle
      @(negedge clk);
      flush = 1'b1;
      start = 1'b1;
      op = OP_MULT;
      @(posedge clk);
      #1 begin flush = 1'b0; start = 1'b0; end
      @(negedge clk);
      check("idle_flush_state", 64'(dbg_state), 64'(S_IDLE));
      repeat (40) @(negedge clk);

      // result must survive an idle period, then reset mid-operation clears everything at once
      issue(OP_MULTU, 32'd1000, 32'd1000, '0, '0, 1'b1);
      drain();
      repeat (3) @(negedge clk);
      check("hold_lo", 64'(lo_out), 64'd1000000);
      issue(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_0101, '0, '0, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_hilo", {hi_out, lo_out}, 64'd0);
      check("midrst_ready", 64'(ready), 64'd1);
      check("midrst_stall", 64'(stall), 64'd0);
      check("midrst_done_div0", {62'd0, done, div0}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("post_rst_state", 64'(dbg_state), 64'(S_IDLE));

      // one more op after reset to confirm recovery
      issue(OP_MSUB, 32'hFFFF_FFFD, 32'd7, 32'd1, 32'd2, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
